// File: rtl/prog_ack_tx.sv
// Program-loader acknowledge: counts and sums loaded words, sends a 7-byte 8N1 summary frame on done_i rise.
// Latency: first start bit one cycle after the start cycle; frame lasts exactly 70 bit periods.
// Backpressure: none; start conditions while busy are dropped, word accumulation never stalls.
module prog_ack_tx (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] clks_per_bit_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic        done_i,
  output logic        tx_o,
  output logic        tx_en_o,
  output logic        busy_o,
  output logic        frame_sent_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  state_t      state_q, state_d;
  logic        done_q;
  logic [15:0] word_cnt_q;
  logic [31:0] sum_q;
  logic [15:0] frame_cnt_q;
  logic [31:0] frame_sum_q;
  logic [15:0] period_q;
  logic [15:0] cyc_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [2:0]  byte_idx_q;
  logic        start_evt;
  logic        bit_end;
  logic        in_frame;
  logic [7:0]  tx_byte;

  // A frame may only begin from IDLE, on the cycle done_i is first seen high.
  assign start_evt = (state_q == S_IDLE) && done_i && !done_q;
  assign in_frame  = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
  assign bit_end   = (cyc_cnt_q == (period_q - 16'd1));

  // Edge detector history; resets high so a level already asserted at reset release is ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= 1'b1;
    end else begin
      done_q <= done_i;
    end
  end

  // Word count and checksum of the current loading session; restarted at each frame start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_cnt_q <= 16'd0;
      sum_q      <= 32'd0;
    end else if (start_evt) begin
      // A write landing in the start cycle belongs to the new session.
      word_cnt_q <= we_i ? 16'd1 : 16'd0;
      sum_q      <= we_i ? wdata_i : 32'd0;
    end else if (we_i) begin
      if (word_cnt_q != 16'hFFFF) begin
        word_cnt_q <= word_cnt_q + 16'd1;
      end
      sum_q <= sum_q + wdata_i;
    end
  end

  // Snapshot of session totals and bit period, frozen for the duration of the frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_cnt_q <= 16'd0;
      frame_sum_q <= 32'd0;
      period_q    <= 16'd1;
    end else if (start_evt) begin
      frame_cnt_q <= word_cnt_q;
      frame_sum_q <= sum_q;
      period_q    <= (clks_per_bit_i == 16'd0) ? 16'd1 : clks_per_bit_i;
    end
  end

  // Bit period timer plus bit and byte position within the frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_cnt_q  <= 16'd0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 3'd0;
    end else if (start_evt) begin
      cyc_cnt_q  <= 16'd0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 3'd0;
    end else if (in_frame) begin
      if (bit_end) begin
        cyc_cnt_q <= 16'd0;
        if (state_q == S_DATA) begin
          bit_idx_q <= bit_idx_q + 3'd1;
        end
        if (state_q == S_STOP) begin
          byte_idx_q <= byte_idx_q + 3'd1;
        end
      end else begin
        cyc_cnt_q <= cyc_cnt_q + 16'd1;
      end
    end
  end

  // Frame byte selected by position: sync byte, count MSB first, sum MSB first.
  always_comb begin
    tx_byte = SYNC_BYTE;
    case (byte_idx_q)
      3'd0:    tx_byte = SYNC_BYTE;
      3'd1:    tx_byte = frame_cnt_q[15:8];
      3'd2:    tx_byte = frame_cnt_q[7:0];
      3'd3:    tx_byte = frame_sum_q[31:24];
      3'd4:    tx_byte = frame_sum_q[23:16];
      3'd5:    tx_byte = frame_sum_q[15:8];
      3'd6:    tx_byte = frame_sum_q[7:0];
      default: tx_byte = SYNC_BYTE;
    endcase
  end

  // FSM state register; reset aborts any frame in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: start bit, eight data bits, stop bit, repeated for seven bytes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_evt) state_d = S_START;
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end && (bit_idx_q == 3'd7)) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) state_d = (byte_idx_q == 3'd6) ? S_DONE : S_START;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM outputs decoded from state so reset forces the line idle immediately.
  always_comb begin
    tx_o         = 1'b1;
    tx_en_o      = 1'b0;
    busy_o       = 1'b0;
    frame_sent_o = 1'b0;
    case (state_q)
      S_START: begin
        tx_o    = 1'b0;
        tx_en_o = 1'b1;
        busy_o  = 1'b1;
      end
      S_DATA: begin
        tx_o    = tx_byte[bit_idx_q];
        tx_en_o = 1'b1;
        busy_o  = 1'b1;
      end
      S_STOP: begin
        tx_o    = 1'b1;
        tx_en_o = 1'b1;
        busy_o  = 1'b1;
      end
      S_DONE: begin
        frame_sent_o = 1'b1;
      end
      default: begin
        tx_o = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_prog_ack_tx.sv
// Directed bench for prog_ack_tx: decodes each frame off tx_o and compares with hand-computed bytes.
// Inputs change and outputs are sampled on the falling edge of clk_i.
// Every wait on the DUT is bounded.
module tb_prog_ack_tx;

  logic        clk_i;
  logic        rst_ni;
  logic [15:0] clks_per_bit_i;
  logic        we_i;
  logic [31:0] wdata_i;
  logic        done_i;
  logic        tx_o;
  logic        tx_en_o;
  logic        busy_o;
  logic        frame_sent_o;

  int n_checks;
  int n_fail;

  // Results of the most recent frame capture.
  logic [7:0]  rx_b [7];
  logic [69:0] rx_bits;
  int          rx_en_cnt;
  int          rx_early_sent;
  int          rx_extra;
  logic        rx_sent_end;
  logic        rx_en_end;
  logic        rx_tx_end;
  logic        rx_bit_ok;
  logic        rx_busy_ok;
  logic        rx_framing_ok;

  int          watch_en;
  int          watch_sent;

  prog_ack_tx dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clks_per_bit_i (clks_per_bit_i),
    .we_i           (we_i),
    .wdata_i        (wdata_i),
    .done_i         (done_i),
    .tx_o           (tx_o),
    .tx_en_o        (tx_en_o),
    .busy_o         (busy_o),
    .frame_sent_o   (frame_sent_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Record one frame starting at the first negedge where tx_en_o is high.
  task automatic capture(input int c);
    int   waited;
    logic cur;
    waited = 0;
    cur    = 1'b1;
    while (tx_en_o !== 1'b1 && waited < 400) begin
      @(negedge clk_i);
      waited++;
    end
    rx_en_cnt     = 0;
    rx_early_sent = 0;
    rx_extra      = 0;
    rx_bit_ok     = 1'b1;
    rx_busy_ok    = 1'b1;
    rx_framing_ok = 1'b1;
    rx_bits       = '0;
    rx_sent_end   = 1'b0;
    rx_en_end     = 1'b1;
    rx_tx_end     = 1'b0;
    for (int j = 0; j < 7; j++) rx_b[j] = 8'h00;
    if (tx_en_o !== 1'b1) begin
      chk("frame_start_timeout", 64'd0, 64'd1);
      return;
    end
    for (int k = 0; k < 70 * c; k++) begin
      if (k % c == 0) cur = tx_o;
      else if (tx_o !== cur) rx_bit_ok = 1'b0;
      if (k % c == c / 2) rx_bits[k / c] = tx_o;
      if (tx_en_o === 1'b1) rx_en_cnt++;
      if (busy_o !== tx_en_o) rx_busy_ok = 1'b0;
      if (frame_sent_o !== 1'b0) rx_early_sent++;
      @(negedge clk_i);
    end
    rx_sent_end = frame_sent_o;
    rx_en_end   = tx_en_o;
    rx_tx_end   = tx_o;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      if (frame_sent_o !== 1'b0 || tx_en_o !== 1'b0) rx_extra++;
    end
    for (int j = 0; j < 7; j++) begin
      if (rx_bits[j * 10] !== 1'b0 || rx_bits[j * 10 + 9] !== 1'b1) rx_framing_ok = 1'b0;
      for (int b = 0; b < 8; b++) rx_b[j][b] = rx_bits[j * 10 + 1 + b];
    end
  endtask

  task automatic chk_frame(input string tag, input logic [55:0] exp_bytes, input int c);
    chk({tag, "_bytes"}, {8'h00, rx_b[0], rx_b[1], rx_b[2], rx_b[3], rx_b[4], rx_b[5], rx_b[6]},
        {8'h00, exp_bytes});
    chk({tag, "_en_cycles"}, rx_en_cnt, 70 * c);
    chk({tag, "_bit_hold"}, rx_bit_ok, 1'b1);
    chk({tag, "_framing"}, rx_framing_ok, 1'b1);
    chk({tag, "_busy_eq_en"}, rx_busy_ok, 1'b1);
    chk({tag, "_sent_early"}, rx_early_sent, 0);
    chk({tag, "_sent_pulse"}, rx_sent_end, 1'b1);
    chk({tag, "_en_at_pulse"}, rx_en_end, 1'b0);
    chk({tag, "_tx_idle_at_pulse"}, rx_tx_end, 1'b1);
    chk({tag, "_after_quiet"}, rx_extra, 0);
  endtask

  task automatic write_word(input logic [31:0] d);
    we_i    = 1'b1;
    wdata_i = d;
    @(negedge clk_i);
    we_i    = 1'b0;
    wdata_i = 32'h0;
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_ni         = 1'b0;
    clks_per_bit_i = 16'd4;
    we_i           = 1'b0;
    wdata_i        = 32'h0;
    done_i         = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk_i);
    chk("rst_tx", tx_o, 1'b1);
    chk("rst_tx_en", tx_en_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_sent", frame_sent_o, 1'b0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // Three writes, C=4: count 3, sum wraps to 0x13.
    write_word(32'h0000_0013);
    write_word(32'h0000_0001);
    write_word(32'hFFFF_FFFF);
    repeat (2) @(negedge clk_i);
    chk("t1_idle_before_start", tx_en_o, 1'b0);
    done_i = 1'b1;
    @(negedge clk_i);
    chk("t1_start_bit_next_cycle_en", tx_en_o, 1'b1);
    chk("t1_start_bit_next_cycle_tx", tx_o, 1'b0);
    capture(4);
    chk_frame("t1", 56'hA5_0003_0000_0013, 4);
    chk("t1_a5_bit_sequence", rx_bits[9:0], 10'b1101001010);

    // clks_per_bit_i=0 acts as 1; a mid-frame change to 8 is ignored.
    clks_per_bit_i = 16'd0;
    done_i = 1'b0;
    @(negedge clk_i);
    done_i = 1'b1;
    @(negedge clk_i);
    fork
      capture(1);
      begin
        repeat (20) @(negedge clk_i);
        clks_per_bit_i = 16'd8;
      end
    join
    chk_frame("t2", 56'hA5_0000_0000_0000, 1);

    // Writes and a second done_i rise during transmission.
    clks_per_bit_i = 16'd4;
    done_i = 1'b0;
    @(negedge clk_i);
    done_i = 1'b1;
    @(negedge clk_i);
    fork
      capture(4);
      begin
        repeat (30) @(negedge clk_i);
        write_word(32'h0000_0005);
        write_word(32'h0000_0007);
        repeat (10) @(negedge clk_i);
        done_i = 1'b0;
        @(negedge clk_i);
        done_i = 1'b1;
      end
    join
    chk_frame("t3a", 56'hA5_0000_0000_0000, 4);
    done_i = 1'b0;
    @(negedge clk_i);
    done_i = 1'b1;
    @(negedge clk_i);
    capture(4);
    chk_frame("t3b", 56'hA5_0002_0000_000C, 4);

    // Reset at cycle 100 of a frame, with writes both before and during it.
    write_word(32'h0000_0001);
    write_word(32'h0000_0002);
    write_word(32'h0000_0003);
    done_i = 1'b0;
    @(negedge clk_i);
    done_i = 1'b1;
    @(negedge clk_i);
    chk("t4_frame_running", tx_en_o, 1'b1);
    write_word(32'h0000_0009);
    write_word(32'h0000_0009);
    repeat (98) @(negedge clk_i);
    chk("t4_tx_low_before_reset", tx_o, 1'b0);
    rst_ni = 1'b0;
    #1;
    chk("t4_rst_tx_same_cycle", tx_o, 1'b1);
    chk("t4_rst_en_same_cycle", tx_en_o, 1'b0);
    chk("t4_rst_busy_same_cycle", busy_o, 1'b0);
    watch_sent = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (frame_sent_o !== 1'b0) watch_sent++;
    end
    rst_ni = 1'b1;

    // done_i already high at release must not start a frame.
    watch_en = 0;
    repeat (100) begin
      @(negedge clk_i);
      if (tx_en_o !== 1'b0) watch_en++;
      if (frame_sent_o !== 1'b0) watch_sent++;
    end
    chk("t4_no_frame_after_release", watch_en, 0);
    chk("t4_no_sent_after_abort", watch_sent, 0);
    done_i = 1'b0;
    @(negedge clk_i);
    done_i = 1'b1;
    @(negedge clk_i);
    capture(4);
    chk_frame("t4", 56'hA5_0000_0000_0000, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_ack_tx.md
PROG_ACK_TX -- requirements
Module: prog_ack_tx

Interface
REQ-001 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port clks_per_bit_i  input  16  UART bit period in clk_i cycles.
REQ-004 SHALL have port we_i  input  1  program-loader instruction-RAM write strobe, one word per high cycle.
REQ-005 SHALL have port wdata_i  input  32  word written when we_i high.
REQ-006 SHALL have port done_i  input  1  loader core-release level; high = programming finished.
REQ-007 SHALL have port tx_o  output  1  UART serial output to host, idle high.
REQ-008 SHALL have port tx_en_o  output  1  high while frame on tx_o; pad mux selects tx_o over GPIO.
REQ-009 SHALL have port busy_o  output  1  identical to tx_en_o.
REQ-010 SHALL have port frame_sent_o  output  1  one-cycle pulse at frame completion.

Function
REQ-011 SHALL hold 16-bit word_cnt and 32-bit sum accumulators.
REQ-012 SHALL, each cycle with we_i=1, increment word_cnt (saturating at 0xFFFF) and add wdata_i to sum modulo 2^32.
REQ-013 SHALL register done_i into done_q every cycle; start condition = done_i=1 and done_q=0 while idle.
REQ-014 SHALL, in the start cycle, snapshot word_cnt and sum into frame registers and clear both accumulators; a we_i in that cycle counts toward the new session, not the snapshot.
REQ-015 SHALL ignore start conditions while busy (no queuing); accumulation continues during transmission.
REQ-016 SHALL send a 7-byte frame: 0xA5, cnt[15:8], cnt[7:0], sum[31:24], sum[23:16], sum[15:8], sum[7:0].
REQ-017 SHALL encode each byte 8N1: start bit 0, eight data bits LSB first, stop bit 1; no gap between bytes.
REQ-018 SHALL hold each bit for C cycles, C = clks_per_bit_i sampled in start cycle; value 0 treated as 1; input changes mid-frame ignored.
REQ-019 SHALL drive the first start bit on tx_o in the cycle after the start cycle; frame lasts exactly 70*C cycles.
REQ-020 SHALL use FSM IDLE -> START -> DATA(bit 0..7) -> STOP -> next byte START, or DONE after byte 6 stop -> IDLE.
REQ-021 SHALL assert tx_en_o/busy_o from first start-bit cycle through last stop-bit cycle inclusive.
REQ-022 SHALL pulse frame_sent_o in the single cycle following the last stop-bit cycle, with tx_en_o=0 in that cycle.
REQ-023 SHALL keep tx_o=1 whenever not transmitting.
REQ-024 SHALL send frame to completion even if done_i falls mid-frame.

Reset
REQ-025 SHALL, on rst_ni=0, immediately force tx_o=1, tx_en_o=0, busy_o=0, frame_sent_o=0, FSM IDLE, accumulators and frame registers 0.
REQ-026 SHALL reset done_q to 1, so a done_i already high at reset release does not start a frame; done_i must be seen low first.
REQ-027 SHALL, on reset asserted mid-frame, abort the frame (tx_o=1 immediately) and not resume it after release.

Verification
REQ-028 SHALL check: C=4, done_i low, writes 0x00000013, 0x00000001, 0xFFFFFFFF, then done_i rise -> bytes A5 00 03 00 00 00 13, 280 tx_en cycles, one frame_sent_o pulse.
REQ-029 SHALL check: first byte 0xA5 -> tx_o bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, start bit one cycle after edge.
REQ-030 SHALL check: clks_per_bit_i=0 -> bits one cycle each, frame 70 cycles; changing clks_per_bit_i to 8 mid-frame -> no period change.
REQ-031 SHALL check: done_i high at reset release, no writes -> no frame; done_i low one cycle then high -> frame A5 00 00 00 00 00 00.
REQ-032 SHALL check: 2 writes during transmission, second done_i rise during transmission -> ignored; next rise after frame -> count 0x0002.
REQ-033 SHALL check: rst_ni low at cycle 100 of a frame -> tx_o=1, tx_en_o=0 same cycle, no frame_sent_o, counters 0.
